// File: rtl/seg7_scan.sv
// Four-digit multiplexed 7-segment scanner: synchronises the scan-rate input,
// snapshots display data once per frame and drives registered anode/cathode lines.
module seg7_scan #(
  parameter int BLINK_BITS = 6
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        segclk,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  input  logic        blink_en,
  input  logic [3:0]  blink_mask,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  logic                  s0_q, s1_q, s2_q, s0_d, s1_d, s2_d;
  logic                  load_q, load_d;
  logic [1:0]            sel_q, sel_d;
  logic [15:0]           sh_digits_q, sh_digits_d;
  logic [3:0]            sh_dp_q, sh_dp_d;
  logic [3:0]            sh_mask_q, sh_mask_d;
  logic [BLINK_BITS-1:0] blink_cnt_q, blink_cnt_d;
  logic [3:0]            an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;

  logic       tick_s;
  logic [3:0] nibble_s;
  logic       lz_blank_s;
  logic       blink_blank_s;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0:    hex7 = 7'h40;
      4'h1:    hex7 = 7'h79;
      4'h2:    hex7 = 7'h24;
      4'h3:    hex7 = 7'h30;
      4'h4:    hex7 = 7'h19;
      4'h5:    hex7 = 7'h12;
      4'h6:    hex7 = 7'h02;
      4'h7:    hex7 = 7'h78;
      4'h8:    hex7 = 7'h00;
      4'h9:    hex7 = 7'h10;
      4'hA:    hex7 = 7'h08;
      4'hB:    hex7 = 7'h03;
      4'hC:    hex7 = 7'h46;
      4'hD:    hex7 = 7'h21;
      4'hE:    hex7 = 7'h06;
      4'hF:    hex7 = 7'h0E;
      default: hex7 = 7'h7F;
    endcase
  endfunction

  // Active-digit nibble and blanking decisions, taken from shadow data at the current sel
  always_comb begin
    nibble_s   = 4'h0;
    lz_blank_s = 1'b0;
    case (sel_q)
      2'd0: begin
        nibble_s   = sh_digits_q[3:0];
        lz_blank_s = 1'b0;
      end
      2'd1: begin
        nibble_s   = sh_digits_q[7:4];
        lz_blank_s = (sh_digits_q[15:4] == 12'h000);
      end
      2'd2: begin
        nibble_s   = sh_digits_q[11:8];
        lz_blank_s = (sh_digits_q[15:8] == 8'h00);
      end
      2'd3: begin
        nibble_s   = sh_digits_q[15:12];
        lz_blank_s = (sh_digits_q[15:12] == 4'h0);
      end
      default: begin
        nibble_s   = 4'h0;
        lz_blank_s = 1'b0;
      end
    endcase
    blink_blank_s = blink_en & sh_mask_q[sel_q] & blink_cnt_q[BLINK_BITS-1];
  end

  // Next-state logic: synchroniser, digit select, frame snapshot and output load
  always_comb begin
    tick_s      = s1_q & ~s2_q;
    s0_d        = segclk;
    s1_d        = s0_q;
    s2_d        = s1_q;
    load_d      = tick_s;
    sel_d       = sel_q;
    sh_digits_d = sh_digits_q;
    sh_dp_d     = sh_dp_q;
    sh_mask_d   = sh_mask_q;
    blink_cnt_d = blink_cnt_q;
    an_d        = an_q;
    seg_d       = seg_q;
    dp_d        = dp_q;

    if (tick_s) begin
      sel_d = sel_q + 2'd1;
      // The wrap tick starts a new frame: take a coherent snapshot of all display data
      if (sel_q == 2'd3) begin
        sh_digits_d = digits;
        sh_dp_d     = dp_in;
        sh_mask_d   = blink_mask;
        blink_cnt_d = blink_cnt_q + BLINK_BITS'(1);
      end else begin
        sh_digits_d = sh_digits_q;
      end
    end else begin
      sel_d = sel_q;
    end

    if (load_q) begin
      if ((blank_lz & lz_blank_s) | blink_blank_s) begin
        an_d  = 4'hF;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
      end else begin
        an_d  = ~(4'b0001 << sel_q);
        seg_d = hex7(nibble_s);
        dp_d  = ~sh_dp_q[sel_q];
      end
    end else begin
      an_d = an_q;
    end
  end

  // State registers with synchronous clear
  always_ff @(posedge clk) begin
    if (clr) begin
      s0_q        <= 1'b0;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      load_q      <= 1'b0;
      sel_q       <= 2'd3;
      sh_digits_q <= 16'h0000;
      sh_dp_q     <= 4'h0;
      sh_mask_q   <= 4'h0;
      blink_cnt_q <= '0;
      an_q        <= 4'hF;
      seg_q       <= 7'h7F;
      dp_q        <= 1'b1;
    end else begin
      s0_q        <= s0_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      load_q      <= load_d;
      sel_q       <= sel_d;
      sh_digits_q <= sh_digits_d;
      sh_dp_q     <= sh_dp_d;
      sh_mask_q   <= sh_mask_d;
      blink_cnt_q <= blink_cnt_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan: each segclk pulse pushes its hand-computed display
// word; a monitor predicts the load edge from segclk timing, pops and compares.
module tb_seg7_scan;

  logic        clk = 1'b0;
  logic        clr;
  logic        segclk;
  logic [15:0] digits;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic        blink_en;
  logic [3:0]  blink_mask;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } disp_t;

  localparam disp_t BLANK = '{an: 4'hF, seg: 7'h7F, dp: 1'b1};

  disp_t exp_q[$];
  disp_t last;
  int    checks = 0;
  int    errors = 0;
  bit    armed  = 1'b0;
  bit    p0, p1, p2, ldp, load_now, was_load;

  always #10 clk = ~clk;

  seg7_scan #(.BLINK_BITS(2)) dut (
    .clk(clk), .clr(clr), .segclk(segclk), .digits(digits), .dp_in(dp_in),
    .blank_lz(blank_lz), .blink_en(blink_en), .blink_mask(blink_mask),
    .an(an), .seg(seg), .dp(dp)
  );

  // Monitor: timing model of the 3-flop synchroniser decides when outputs reload
  always begin
    @(posedge clk);
    was_load = 1'b0;
    if (clr) begin
      p0 = 1'b0; p1 = 1'b0; p2 = 1'b0; ldp = 1'b0;
      last  = BLANK;
      armed = 1'b1;
    end else begin
      load_now = ldp;
      ldp = p1 & ~p2;
      p2 = p1; p1 = p0; p0 = segclk;
      if (load_now) begin
        was_load = 1'b1;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL load: predicted output load at %0t with empty queue", $time);
        end else begin
          last = exp_q.pop_front();
        end
      end
    end
    @(negedge clk);
    if (armed) begin
      checks++;
      if ({an, seg, dp} !== last) begin
        errors++;
        $display("FAIL %s @%0t: got an=%h seg=%h dp=%b, want an=%h seg=%h dp=%b",
                 was_load ? "load" : "hold", $time, an, seg, dp, last.an, last.seg, last.dp);
      end
    end
  end

  task automatic pulse(input int hi, input int lo);
    segclk = 1'b1;
    repeat (hi) @(negedge clk);
    segclk = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic step(input logic [3:0] a, input logic [6:0] s, input logic d);
    disp_t e;
    e = '{an: a, seg: s, dp: d};
    exp_q.push_back(e);
    pulse(3, 4);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  bit phase_tab [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    clr = 1'b1; segclk = 1'b0; digits = 16'h12AF; dp_in = 4'h0;
    blank_lz = 1'b0; blink_en = 1'b0; blink_mask = 4'h0;
    repeat (3) @(negedge clk);
    clr = 1'b0;
    repeat (5) @(negedge clk);

    // Basic scan of 12AF
    step(4'hE, 7'h0E, 1'b1);
    step(4'hD, 7'h08, 1'b1);
    step(4'hB, 7'h24, 1'b1);
    step(4'h7, 7'h79, 1'b1);

    // 1111 frame with a long constant-high segclk; change to 2222 while sel==1
    digits = 16'h1111;
    exp_q.push_back('{an: 4'hE, seg: 7'h79, dp: 1'b1});
    pulse(30, 30);
    step(4'hD, 7'h79, 1'b1);
    digits = 16'h2222;
    step(4'hB, 7'h79, 1'b1);
    step(4'h7, 7'h79, 1'b1);
    step(4'hE, 7'h24, 1'b1);
    step(4'hD, 7'h24, 1'b1);
    step(4'hB, 7'h24, 1'b1);
    step(4'h7, 7'h24, 1'b1);

    // Leading-zero blanking
    digits = 16'h0005; blank_lz = 1'b1;
    step(4'hE, 7'h12, 1'b1);
    step(4'hF, 7'h7F, 1'b1);
    step(4'hF, 7'h7F, 1'b1);
    step(4'hF, 7'h7F, 1'b1);
    digits = 16'h0000;
    step(4'hE, 7'h40, 1'b1);
    step(4'hF, 7'h7F, 1'b1);
    step(4'hF, 7'h7F, 1'b1);
    step(4'hF, 7'h7F, 1'b1);
    digits = 16'h0100;
    step(4'hE, 7'h40, 1'b1);
    step(4'hD, 7'h40, 1'b1);
    step(4'hB, 7'h79, 1'b1);
    step(4'hF, 7'h7F, 1'b1);
    blank_lz = 1'b0;

    // Blink on digit 0 with its decimal point; counter restarts from clear
    do_clr();
    digits = 16'h4321; dp_in = 4'b0001; blink_mask = 4'b0001; blink_en = 1'b1;
    for (int f = 0; f < 5; f++) begin
      if (phase_tab[f]) step(4'hF, 7'h7F, 1'b1);
      else              step(4'hE, 7'h79, 1'b0);
      step(4'hD, 7'h24, 1'b1);
      step(4'hB, 7'h30, 1'b1);
      step(4'h7, 7'h19, 1'b1);
    end
    blink_en = 1'b0; dp_in = 4'h0; blink_mask = 4'h0;

    // Clear coincident with the tick edge at sel==2
    do_clr();
    digits = 16'h12AF;
    step(4'hE, 7'h0E, 1'b1);
    step(4'hD, 7'h08, 1'b1);
    step(4'hB, 7'h24, 1'b1);
    digits = 16'h3456;
    segclk = 1'b1;
    repeat (2) @(negedge clk);
    clr = 1'b1; segclk = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    repeat (6) @(negedge clk);
    step(4'hE, 7'h02, 1'b1);
    step(4'hD, 7'h12, 1'b1);
    step(4'hB, 7'h19, 1'b1);
    step(4'h7, 7'h30, 1'b1);

    repeat (10) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected loads never happened, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
